alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational `alu` instance between two requesters, e.g. the two cores' execute stages in multicore bring-up, or a core plus a board-level test driver. Each requester presents an opcode and two 32-bit operands with a `req`/`gnt`/`done` handshake. The block arbitrates round-robin, latches the winner's operands, evaluates them on the shared ALU, and returns a registered result with flags to the winner. It sits between the requesters and the `alu` instance, which is driven through `alu_if`.

## Interface
Parameters:
- `RR_INIT_LAST`, default 1: reset value of the round-robin "last granted" pointer. With 1, requester 0 wins the first tie.

Ports:
- `CLOCK_50`  in  1  system clock; all state updates on the rising edge
- `RESET`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  request from requester 0 / 1
- `aluop0`, `aluop1`  in  4  ALU opcode per requester, `alu_if.aluop` encoding
- `portA0`, `portB0`, `portA1`, `portB1`  in  32  operands per requester
- `gnt0`, `gnt1`  out  1  one-cycle pulse: that requester's operands were captured
- `done0`, `done1`  out  1  one-cycle pulse: `result`/flags belong to that requester
- `result`  out  32  registered ALU `outport`
- `negative`, `overflow`, `zero`  out  1  registered ALU flags
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE:
    - If no `req`, stay in IDLE.
    - If any `req` is high, pick the winner, capture `aluop`/`portA`/`portB` into operand registers, record `owner`, and go to EXEC.
  - EXEC: the latched operands drive `alu_if`. Register `outport` and the flags into `result`/flags, then go to DONE.
  - DONE: unconditionally go to IDLE.
- Arbitration, sampled only in IDLE:
  - Single request: grant it.
  - Both requests: grant the requester ≠ `last`.
  - `last` ← `owner` on every capture.
- `gnt[owner]` is high only during EXEC. `done[owner]` is high only during DONE. The non-owner's `gnt`/`done` stay 0.
- Requester rules:
  - Operands need to be valid only in the cycle before the capture edge. Changes after `gnt` do not affect the in-flight op.
  - `req` held high through `done` is a new request, sampled in the following IDLE cycle.
  - To issue exactly one op, a requester drops `req` no later than the cycle in which `done` is high.
- `result`/flags hold their value until the next EXEC→DONE edge and remain readable after `done`.
- Width rules:
  - 32-bit wrap-around arithmetic, exactly as the ALU produces it.
  - The block never modifies ALU outputs.

## Timing
- Capture at edge k (IDLE→EXEC).
- `gnt` is high in cycle k+1.
- Result is registered at edge k+1.
- `done` and valid `result` are in cycle k+2.
- IDLE in cycle k+3. Earliest next capture is edge k+3.
- Throughput is 1 op per 3 cycles. Latency from capture edge to `done` is 2 cycles.
- Reset values:
  - state = IDLE
  - `last` = `RR_INIT_LAST`
  - `gnt0`/`gnt1`/`done0`/`done1`/`busy` = 0
  - `result` = 0
  - `negative`/`overflow`/`zero` = 0
  - operand registers = 0
- `RESET` mid-operation (EXEC or DONE):
  - Abort at that edge.
  - No `done` is issued for the aborted op.
  - `last` returns to `RR_INIT_LAST`.
- `RESET` has priority over all requests in the same cycle.
- A `req` that drops between the IDLE sample edge and `done` does not cancel the op; `done` still pulses.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, requester 0 always wins ties. `last` is not implemented and `RR_INIT_LAST` is ignored.
  - Undefined (default): round-robin as above.
- Handshake, FSM and timing are identical in both builds.

## Test plan
- Reset then `req0`=1 with add opcode, A=0x00000005, B=0x00000003 → `gnt0` in cycle k+1, `done0` in cycle k+2, `result`=0x00000008, `zero`=0, `gnt1`/`done1` never asserted.
- `req0` and `req1` held high continuously (add 1+1 and sub 0x10−0x01) → grants alternate 0,1,0,1, one `done` every 3 cycles. Under `ALU_ARB_FIXED_PRIO_EN`, all grants go to 0.
- `req1` with sub A=B=0x12345678 → `result`=0, `zero`=1 with `done1`. Then add 0x7FFFFFFF+1 → `result`=0x80000000, `overflow`=1, `negative`=1.
- Change `portA0` to 0xFFFFFFFF in the cycle `gnt0` is high → `result` reflects the captured operands, not the new value.
- Assert `RESET` in the EXEC cycle of a `req1` op → no `done1`, `busy`=0 next cycle, `result`=0. The next tie goes to requester 0.
- `req0` pulsed for exactly 1 cycle in IDLE → exactly one `gnt0`/`done0` pair, then `busy`=0 and the block stays idle.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU (alu_if opcode set).
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority to requester 0.
module alu_arbiter #(
    parameter logic RR_INIT_LAST = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  aluop0,
    input  logic [3:0]  aluop1,
    input  logic [31:0] portA0,
    input  logic [31:0] portB0,
    input  logic [31:0] portA1,
    input  logic [31:0] portB1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        negative,
    output logic        overflow,
    output logic        zero,
    output logic        busy
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q;
    logic        owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        last_q;
`endif
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
    logic [31:0] result_q;
    logic        neg_q, ovf_q, zero_q;

    logic        winner_s;
    logic [3:0]  cap_op_s;
    logic [31:0] cap_a_s;
    logic [31:0] cap_b_s;
    logic [31:0] alu_out_s;
    logic        alu_ovf_s;

    // Arbitration: a lone request wins; a tie goes to whoever was not served last.
    always_comb begin
        winner_s = 1'b0;
        if (req0 && req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            winner_s = 1'b0;
`else
            winner_s = ~last_q;
`endif
        end else if (req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign cap_op_s = winner_s ? aluop1 : aluop0;
    assign cap_a_s  = winner_s ? portA1 : portA0;
    assign cap_b_s  = winner_s ? portB1 : portB0;

    // Shared combinational ALU fed only from the latched operands.
    always_comb begin
        alu_out_s = 32'd0;
        alu_ovf_s = 1'b0;
        case (op_q)
            ALU_ADD: begin
                alu_out_s = a_q + b_q;
                alu_ovf_s = (a_q[31] == b_q[31]) && (alu_out_s[31] != a_q[31]);
            end
            ALU_SUB: begin
                alu_out_s = a_q - b_q;
                alu_ovf_s = (a_q[31] != b_q[31]) && (alu_out_s[31] != a_q[31]);
            end
            ALU_AND: alu_out_s = a_q & b_q;
            ALU_OR:  alu_out_s = a_q | b_q;
            ALU_XOR: alu_out_s = a_q ^ b_q;
            ALU_NOR: alu_out_s = ~(a_q | b_q);
            ALU_SLL: alu_out_s = a_q << b_q[4:0];
            ALU_SRL: alu_out_s = a_q >> b_q[4:0];
            ALU_SRA: alu_out_s = $unsigned($signed(a_q) >>> b_q[4:0]);
            ALU_SLT: alu_out_s = {31'd0, ($signed(a_q) < $signed(b_q))};
            default: alu_out_s = 32'd0;
        endcase
    end

    // Handshake FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q   <= RR_INIT_LAST;
`endif
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 32'd0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    if (req0 || req1) begin
                        state_q <= EXEC;
                        owner_q <= winner_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_q  <= winner_s;
`endif
                        op_q    <= cap_op_s;
                        a_q     <= cap_a_s;
                        b_q     <= cap_b_s;
                        gnt0_q  <= ~winner_s;
                        gnt1_q  <= winner_s;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                EXEC: begin
                    state_q  <= DONE;
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    done0_q  <= ~owner_q;
                    done1_q  <= owner_q;
                    busy_q   <= 1'b1;
                    result_q <= alu_out_s;
                    neg_q    <= alu_out_s[31];
                    ovf_q    <= alu_ovf_s;
                    zero_q   <= (alu_out_s == 32'd0);
                end
                DONE: begin
                    state_q <= IDLE;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;
    assign result   = result_q;
    assign negative = neg_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued as stimulus is driven.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  aluop0 = 4'd0, aluop1 = 4'd0;
    logic [31:0] portA0 = 32'd0, portB0 = 32'd0, portA1 = 32'd0, portB1 = 32'd0;
    logic        gnt0, gnt1, done0, done1, negative, overflow, zero, busy;
    logic [31:0] result;

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic        n;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   cyc_cnt = 0;

    alu_arbiter dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET),
        .req0(req0), .req1(req1), .aluop0(aluop0), .aluop1(aluop1),
        .portA0(portA0), .portB0(portB0), .portA1(portA1), .portB1(portB1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .negative(negative), .overflow(overflow), .zero(zero),
        .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_gnt(output logic who, output logic ok);
        ok = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                ok = 1'b1;
                who = gnt1;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic who, output logic ok);
        ok = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0 || done1) begin
                ok = 1'b1;
                who = done1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({gnt0, gnt1, done0, done1, busy, negative, overflow, zero} !== 8'h00)
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {gnt0, gnt1, done0, done1, busy, negative, overflow, zero});
        else pass_cnt++;
        chk_cnt++;
        if (result !== 32'd0) $display("FAIL reset_result: got %h want 00000000", result);
        else pass_cnt++;
    endtask

    task automatic test_single();
        exp_t e;
        sb.push_back('{1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0});
        aluop0 = OP_ADD; portA0 = 32'h5; portB0 = 32'h3; req0 = 1'b1;
        tick();
        chk_cnt++;
        if ({gnt0, gnt1, busy} !== 3'b101) $display("FAIL single_gnt: got %b want 101", {gnt0, gnt1, busy});
        else pass_cnt++;
        req0 = 1'b0;
        tick();
        chk_cnt++;
        if ({done0, done1} !== 2'b10) $display("FAIL single_done: got %b want 10", {done0, done1});
        else pass_cnt++;
        e = sb.pop_front();
        chk_cnt++;
        if ({result, negative, overflow, zero} !== {e.res, e.n, e.v, e.z})
            $display("FAIL single_result: got %h/%b%b%b want %h/%b%b%b",
                     result, negative, overflow, zero, e.res, e.n, e.v, e.z);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({busy, done0, gnt0, gnt1, done1} !== 5'b00000)
            $display("FAIL single_idle: got %b want 00000", {busy, done0, gnt0, gnt1, done1});
        else pass_cnt++;
        chk_cnt++;
        if (result !== e.res) $display("FAIL single_hold: got %h want %h", result, e.res);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic who, ok, exp_owner;
        int last_done;
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_owner = 1'b0;
`else
            exp_owner = (i % 2 == 1);
`endif
            if (exp_owner) sb.push_back('{1'b1, 32'h0000_000F, 1'b0, 1'b0, 1'b0});
            else           sb.push_back('{1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0});
        end
        aluop0 = OP_ADD; portA0 = 32'h1;  portB0 = 32'h1;
        aluop1 = OP_SUB; portA1 = 32'h10; portB1 = 32'h1;
        req0 = 1'b1; req1 = 1'b1;
        last_done = 0;
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            wait_gnt(who, ok);
            chk_cnt++;
            if (!ok || who !== e.owner) $display("FAIL rr_grant%0d: got ok=%b who=%b want who=%b", i, ok, who, e.owner);
            else pass_cnt++;
            tick();
            chk_cnt++;
            if ({done0, done1} !== (e.owner ? 2'b01 : 2'b10) || result !== e.res || zero !== e.z)
                $display("FAIL rr_done%0d: got done=%b%b res=%h want owner=%b res=%h",
                         i, done0, done1, result, e.owner, e.res);
            else pass_cnt++;
            if (i > 0) begin
                chk_cnt++;
                if (cyc_cnt - last_done !== 3) $display("FAIL rr_spacing%0d: got %0d want 3", i, cyc_cnt - last_done);
                else pass_cnt++;
            end
            last_done = cyc_cnt;
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        tick();
        tick();
        chk_cnt++;
        if ({busy, gnt0, gnt1} !== 3'b000) $display("FAIL rr_idle: got %b want 000", {busy, gnt0, gnt1});
        else pass_cnt++;
    endtask

    task automatic test_flags();
        exp_t e;
        logic who, ok;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                sb.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
                aluop1 = OP_SUB; portA1 = 32'h1234_5678; portB1 = 32'h1234_5678;
            end else begin
                sb.push_back('{1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0});
                aluop1 = OP_ADD; portA1 = 32'h7FFF_FFFF; portB1 = 32'h0000_0001;
            end
            req1 = 1'b1;
            wait_gnt(who, ok);
            chk_cnt++;
            if (!ok || who !== 1'b1 || gnt0 !== 1'b0) $display("FAIL flags_gnt%0d: got ok=%b who=%b want who=1", t, ok, who);
            else pass_cnt++;
            req1 = 1'b0;
            wait_done(who, ok);
            e = sb.pop_front();
            chk_cnt++;
            if (!ok || who !== e.owner || done0 !== 1'b0) $display("FAIL flags_done%0d: got ok=%b who=%b want who=%b", t, ok, who, e.owner);
            else pass_cnt++;
            chk_cnt++;
            if ({result, negative, overflow, zero} !== {e.res, e.n, e.v, e.z})
                $display("FAIL flags_result%0d: got %h/%b%b%b want %h/%b%b%b",
                         t, result, negative, overflow, zero, e.res, e.n, e.v, e.z);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_operand_hold();
        exp_t e;
        logic who, ok;
        sb.push_back('{1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0});
        aluop0 = OP_ADD; portA0 = 32'h100; portB0 = 32'h23; req0 = 1'b1;
        wait_gnt(who, ok);
        chk_cnt++;
        if (!ok || who !== 1'b0) $display("FAIL hold_gnt: got ok=%b who=%b want who=0", ok, who);
        else pass_cnt++;
        portA0 = 32'hFFFF_FFFF; portB0 = 32'hFFFF_FFFF; aluop0 = OP_SUB; req0 = 1'b0;
        wait_done(who, ok);
        e = sb.pop_front();
        chk_cnt++;
        if (!ok || who !== e.owner || result !== e.res || negative !== e.n)
            $display("FAIL hold_result: got ok=%b who=%b res=%h want res=%h", ok, who, result, e.res);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_abort();
        exp_t e;
        logic who, ok;
        int dcount;
        aluop1 = OP_SUB; portA1 = 32'h9; portB1 = 32'h4; req1 = 1'b1;
        wait_gnt(who, ok);
        chk_cnt++;
        if (!ok || who !== 1'b1) $display("FAIL abort_gnt: got ok=%b who=%b want who=1", ok, who);
        else pass_cnt++;
        RESET = 1'b1; req1 = 1'b0;
        tick();
        RESET = 1'b0;
        chk_cnt++;
        if ({busy, done1, gnt1} !== 3'b000 || result !== 32'd0)
            $display("FAIL abort_state: got ctl=%b res=%h want ctl=000 res=00000000", {busy, done1, gnt1}, result);
        else pass_cnt++;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done0 || done1) dcount++;
        end
        chk_cnt++;
        if (dcount !== 0) $display("FAIL abort_nodone: got %0d want 0", dcount);
        else pass_cnt++;
        sb.push_back('{1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0});
        aluop0 = OP_ADD; portA0 = 32'h1; portB0 = 32'h1;
        aluop1 = OP_SUB; portA1 = 32'h7; portB1 = 32'h7;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(who, ok);
        req0 = 1'b0; req1 = 1'b0;
        chk_cnt++;
        if (!ok || who !== 1'b0) $display("FAIL abort_tie: got ok=%b who=%b want who=0", ok, who);
        else pass_cnt++;
        wait_done(who, ok);
        e = sb.pop_front();
        chk_cnt++;
        if (!ok || who !== e.owner || result !== e.res) $display("FAIL abort_next: got who=%b res=%h want res=%h", who, result, e.res);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_single_pulse();
        exp_t e;
        int gcount, dcount, other;
        sb.push_back('{1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0});
        aluop0 = OP_ADD; portA0 = 32'h2; portB0 = 32'h3; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        gcount = 0; dcount = 0; other = 0;
        for (int i = 0; i < 9; i++) begin
            if (gnt0) gcount++;
            if (gnt1 || done1) other++;
            if (done0) begin
                dcount++;
                e = sb.pop_front();
                chk_cnt++;
                if (result !== e.res) $display("FAIL pulse_result: got %h want %h", result, e.res);
                else pass_cnt++;
            end
            tick();
        end
        chk_cnt++;
        if (gcount !== 1 || dcount !== 1 || other !== 0)
            $display("FAIL pulse_count: got gnt=%0d done=%0d other=%0d want 1 1 0", gcount, dcount, other);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL pulse_idle: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flags();
        test_operand_hold();
        test_reset_abort();
        test_single_pulse();
        chk_cnt++;
        if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
